// File: rtl/tdc_sample_packer.sv
// TDC sample packer: lanes C_IN_WIDTH samples into C_BUS_WIDTH words behind a FWFT output FIFO.
// Optional SOP/EOP framing with one-word staging: define TDC_PACK_SOP_EOP_EN.
module tdc_sample_packer #(
    parameter int C_IN_WIDTH   = 64,
    parameter int C_BUS_WIDTH  = 256,
    parameter int C_OUT_DEPTH  = 2,
    parameter int REVERSE      = 0,
    parameter int FLUSH_ON_GAP = 1,
    localparam int N  = C_BUS_WIDTH / C_IN_WIDTH,
    localparam int EW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk_capt,
    input  logic                   reset_n,
    input  logic [C_IN_WIDTH-1:0]  S_AVST_DATA,
    input  logic                   S_AVST_VALID,
    output logic                   S_AVST_READY,
    output logic [C_BUS_WIDTH-1:0] M_AVST_DATA,
    output logic                   M_AVST_VALID,
    input  logic                   M_AVST_READY,
    output logic [EW-1:0]          M_AVST_EMPTY,
`ifdef TDC_PACK_SOP_EOP_EN
    output logic                   M_AVST_SOP,
    output logic                   M_AVST_EOP,
`endif
    input  logic                   clr_stats,
    output logic [15:0]            drop_count,
    output logic                   overflow
);

    localparam int AW = $clog2(C_OUT_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(C_OUT_DEPTH);
    localparam logic [EW-1:0] LAST_C = EW'(N - 1);

    logic [C_BUS_WIDTH-1:0] asm_q, asm_d, ins;
    logic [EW-1:0]          idx_q, idx_d;
    logic                   gen_vld, gen_full;
    logic [C_BUS_WIDTH-1:0] gen_data;
    logic [EW-1:0]          gen_empty;
    int                     lane;

    logic                   push;
    logic [C_BUS_WIDTH-1:0] push_data;
    logic [EW-1:0]          push_empty;

    logic [C_BUS_WIDTH-1:0] mem_q [C_OUT_DEPTH];
    logic [EW-1:0]          emem_q [C_OUT_DEPTH];
    logic [AW-1:0]          wr_q, rd_q;
    logic [AW:0]            cnt_q, cnt_d;
    logic                   rdy_q;
    logic                   full, pop, wr_en, drop;
    logic [15:0]            drop_q;
    logic                   ovf_q;
    logic [16:0]            drop_sum;

`ifdef TDC_PACK_SOP_EOP_EN
    logic                   stg_vld_q, stg_vld_d;
    logic [C_BUS_WIDTH-1:0] stg_data_q, stg_data_d;
    logic                   stg_sop_q, stg_sop_d;
    logic                   sop_pend_q, sop_pend_d;
    logic                   push_sop, push_eop;
    logic                   smem_q [C_OUT_DEPTH];
    logic                   pmem_q [C_OUT_DEPTH];
`endif

    // Lane assembly: place sample, complete full words, flush or discard on gaps
    always_comb begin
        asm_d     = asm_q;
        idx_d     = idx_q;
        gen_vld   = 1'b0;
        gen_full  = 1'b0;
        gen_data  = asm_q;
        gen_empty = '0;
        ins       = asm_q;
        lane      = (REVERSE != 0) ? (N - 1 - int'(idx_q)) : int'(idx_q);
        for (int k = 0; k < N; k++) begin
            if (k == lane) ins[k*C_IN_WIDTH +: C_IN_WIDTH] = S_AVST_DATA;
        end
        if (S_AVST_VALID) begin
            if (idx_q == LAST_C) begin
                gen_vld  = 1'b1;
                gen_full = 1'b1;
                gen_data = ins;
                asm_d    = '0;
                idx_d    = '0;
            end else begin
                asm_d = ins;
                idx_d = idx_q + EW'(1);
            end
        end else if (idx_q != '0) begin
            gen_vld   = (FLUSH_ON_GAP != 0);
            gen_empty = EW'(N - int'(idx_q));
            asm_d     = '0;
            idx_d     = '0;
        end
    end

    // Assembly register and lane index
    always_ff @(posedge clk_capt or negedge reset_n) begin
        if (!reset_n) begin
            asm_q <= '0;
            idx_q <= '0;
        end else begin
            asm_q <= asm_d;
            idx_q <= idx_d;
        end
    end

`ifdef TDC_PACK_SOP_EOP_EN
    // Full words wait one cycle in staging so EOP can see whether a gap follows
    always_comb begin
        push       = 1'b0;
        push_data  = gen_data;
        push_empty = gen_empty;
        push_sop   = 1'b0;
        push_eop   = 1'b0;
        stg_vld_d  = gen_vld & gen_full;
        stg_data_d = gen_data;
        stg_sop_d  = sop_pend_q;
        sop_pend_d = sop_pend_q;
        if (stg_vld_q) begin
            push       = 1'b1;
            push_data  = stg_data_q;
            push_empty = '0;
            push_sop   = stg_sop_q;
            push_eop   = ~S_AVST_VALID;
        end else if (gen_vld && !gen_full) begin
            push     = 1'b1;
            push_sop = sop_pend_q;
            push_eop = 1'b1;
        end
        if (!S_AVST_VALID) sop_pend_d = 1'b1;
        else if (gen_vld) sop_pend_d = 1'b0;
    end

    // Staging register and start-of-burst tracking
    always_ff @(posedge clk_capt or negedge reset_n) begin
        if (!reset_n) begin
            stg_vld_q  <= 1'b0;
            stg_data_q <= '0;
            stg_sop_q  <= 1'b0;
            sop_pend_q <= 1'b1;
        end else begin
            stg_vld_q  <= stg_vld_d;
            stg_data_q <= stg_data_d;
            stg_sop_q  <= stg_sop_d;
            sop_pend_q <= sop_pend_d;
        end
    end
`else
    // Words go straight into the FIFO on the completing or gap edge
    always_comb begin
        push       = gen_vld;
        push_data  = gen_data;
        push_empty = gen_empty;
    end
`endif

    assign M_AVST_VALID = (cnt_q != '0);
    assign full  = (cnt_q == DEPTH_C);
    assign pop   = M_AVST_VALID & M_AVST_READY;
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // Occupancy after this cycle's push and pop
    always_comb begin
        cnt_d = cnt_q;
        if (wr_en && !pop) cnt_d = cnt_q + (AW+1)'(1);
        else if (!wr_en && pop) cnt_d = cnt_q - (AW+1)'(1);
    end

    // Output FIFO storage, pointers and registered input-ready advisory
    always_ff @(posedge clk_capt or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            rdy_q <= 1'b0;
            for (int i = 0; i < C_OUT_DEPTH; i++) begin
                mem_q[i]  <= '0;
                emem_q[i] <= '0;
`ifdef TDC_PACK_SOP_EOP_EN
                smem_q[i] <= 1'b0;
                pmem_q[i] <= 1'b0;
`endif
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_q]  <= push_data;
                emem_q[wr_q] <= push_empty;
`ifdef TDC_PACK_SOP_EOP_EN
                smem_q[wr_q] <= push_sop;
                pmem_q[wr_q] <= push_eop;
`endif
                wr_q <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d < DEPTH_C);
        end
    end

    assign drop_sum = {1'b0, drop_q} + 17'(N - int'(push_empty));

    // Drop accounting; a clear in the same cycle as a drop wins
    always_ff @(posedge clk_capt or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else if (clr_stats) begin
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else if (drop) begin
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            ovf_q  <= 1'b1;
        end
    end

    assign M_AVST_DATA  = M_AVST_VALID ? mem_q[rd_q] : '0;
    assign M_AVST_EMPTY = M_AVST_VALID ? emem_q[rd_q] : '0;
`ifdef TDC_PACK_SOP_EOP_EN
    assign M_AVST_SOP   = M_AVST_VALID & smem_q[rd_q];
    assign M_AVST_EOP   = M_AVST_VALID & pmem_q[rd_q];
`endif
    assign S_AVST_READY = rdy_q;
    assign drop_count   = drop_q;
    assign overflow     = ovf_q;

endmodule

// File: doc/tdc_sample_packer.md
Name: tdc_sample_packer

Overview:
Parametrised successor to the TDC top-level packing stage. Packs C_IN_WIDTH-bit TDC samples from the carry-chain capture path into C_BUS_WIDTH-bit DMA words. Adds three things the previous packer lacked: a small output FIFO with real ready/valid backpressure, partial-word flush on burst gaps, and drop accounting. Sits between carry_top and the DC FIFO/DMA, all on the capture clock.

Parameters:
C_IN_WIDTH, 64, sample width in bits; must divide C_BUS_WIDTH; N = C_BUS_WIDTH/C_IN_WIDTH lanes.
C_BUS_WIDTH, 256, output word width in bits.
C_OUT_DEPTH, 2, output FIFO depth in words; power of 2, minimum 2.
REVERSE, 0, lane order. 0: k-th sample of a word goes in lane k (bits k*C_IN_WIDTH upward). 1: k-th sample goes in lane N-1-k.
FLUSH_ON_GAP, 1, 1: emit a partial word when a burst ends. 0: discard the partial word.

Ports:
clk_capt  in  1  capture clock; sole clock.
reset_n  in  1  asynchronous active-low reset.
S_AVST_DATA  in  C_IN_WIDTH  sample from the TDC chain.
S_AVST_VALID  in  1  sample valid; cannot be stalled.
S_AVST_READY  out  1  registered advisory to the pulse generator: FIFO not full.
M_AVST_DATA  out  C_BUS_WIDTH  packed word (FIFO head).
M_AVST_VALID  out  1  FIFO non-empty.
M_AVST_READY  in  1  downstream accept.
M_AVST_EMPTY  out  max(1,$clog2(N))  number of unused lanes in the head word.
clr_stats  in  1  synchronous pulse; clears drop_count and overflow.
drop_count  out  16  saturating count of samples lost.
overflow  out  1  sticky: at least one word dropped.

Behaviour:
- Reset (async, reset_n low) clears:
  - assembly register, lane index idx, FIFO pointers;
  - outputs M_AVST_VALID=0, M_AVST_DATA=0, M_AVST_EMPTY=0, S_AVST_READY=0, drop_count=0, overflow=0.
  - Reset mid-burst discards all held data; no partial flush.
- Assembly:
  - Each cycle with S_AVST_VALID=1, the sample is written to lane f(idx), with f chosen by REVERSE, and idx increments.
  - When idx==N-1 and a sample arrives, the word is complete: the full word is pushed with EMPTY=0, idx returns to 0, and the assembly register is cleared to 0.
- Gap:
  - Cycle with S_AVST_VALID=0 and idx!=0 and FLUSH_ON_GAP=1: push the partial word with unused lanes 0 and EMPTY=N-idx; idx returns to 0.
  - With FLUSH_ON_GAP=0: idx returns to 0 and the partial word is discarded. It is not counted as a drop.
- Push timing: a push happens on the same clock edge as the completing sample or gap; M_AVST_VALID is high the following cycle (latency 1).
- FIFO:
  - First-word-fall-through.
  - Pop when M_AVST_VALID && M_AVST_READY.
  - A push while full is accepted if a pop occurs in the same cycle.
  - A push while full with no pop drops the word: drop_count += number of valid samples in the word (N-EMPTY), saturating at 16'hFFFF; overflow is set.
- S_AVST_READY: registered value of (FIFO count < C_OUT_DEPTH), evaluated after the current push/pop. Advisory only; input is never back-pressured.
- clr_stats: clears drop_count and overflow next cycle. If a drop occurs in the same cycle, clear wins and the drop is not counted.
- N==1: every valid sample is a full word; EMPTY is constant 0; the gap flush never fires.
- Downstream data stability: M_AVST_DATA and M_AVST_EMPTY are stable while M_AVST_VALID=1 && M_AVST_READY=0.

Optional Feature:
Macro TDC_PACK_SOP_EOP_EN.
- Defined: adds outputs M_AVST_SOP and M_AVST_EOP (1 bit each, reset 0), stored per FIFO entry.
  - SOP=1 on the first word pushed after reset or after any gap.
  - EOP=1 on the word pushed by a gap flush, or on the full word completed by the last sample before a gap.
  - EOP requires a one-entry lookahead on the completed word: a full word is held in a staging register for one cycle before pushing, so latency becomes 2 cycles.
- Undefined: no SOP/EOP ports; latency is 1 cycle.

Test Plan:
1. Full words (C_IN_WIDTH=64, N=4, REVERSE=0, ready=1): 8 consecutive samples 0x1..0x8 → two words, {4,3,2,1} and {8,7,6,5} (lane 3..0); EMPTY=0; first VALID one cycle after sample 4.
2. REVERSE=1, same stimulus → words {1,2,3,4} and {5,6,7,8}.
3. Gap flush: samples 0xA, 0xB, then VALID=0 → word {0,0,B,A}, EMPTY=2. Same stimulus with FLUSH_ON_GAP=0 → no word, drop_count=0.
4. Backpressure: M_AVST_READY=0, 16 continuous samples (C_OUT_DEPTH=2):
   - 2 words held, 2 words dropped; drop_count=8, overflow=1;
   - S_AVST_READY falls after the second push;
   - head data stays stable until ready is raised.
5. Simultaneous push/pop at full (READY pulsed on the completing cycle) → no drop; then clr_stats alongside a drop → drop_count=0.
6. reset_n asserted mid-word (idx=2) → all outputs 0 immediately; the next burst starts at lane 0; no partial word emitted.
